// File: rtl/speed_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : speed_step_scheduler
// Brief   : Paced step enable and wrapping position index driven by the
//           speed/pause status. Step period ramps toward the selected speed
//           in bounded increments. Optional macro STEP_DIR_EN adds a dir
//           input that lets pos count downward.
// Rev     : 1.0 - initial release
// ============================================================================
module speed_step_scheduler #(
   parameter int CNT_W       = 27,
   parameter int PERIOD_LOW  = 50000000,
   parameter int PERIOD_MID  = 25000000,
   parameter int PERIOD_HIGH = 12500000,
   parameter int RAMP_STEP   = 2000000,
   parameter int POS_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       status,
   input  logic             clr,
`ifdef STEP_DIR_EN
   input  logic             dir,
`endif
   output logic             step_pulse,
   output logic [POS_W-1:0] pos,
   output logic             wrap,
   output logic             paused,
   output logic             ramping
);

   localparam logic [CNT_W-1:0] c_PERIOD_LOW  = CNT_W'(PERIOD_LOW);
   localparam logic [CNT_W-1:0] c_PERIOD_MID  = CNT_W'(PERIOD_MID);
   localparam logic [CNT_W-1:0] c_PERIOD_HIGH = CNT_W'(PERIOD_HIGH);
   localparam logic [CNT_W-1:0] c_RAMP        = CNT_W'(RAMP_STEP);
   localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);
   localparam logic [1:0]       c_ST_PAUSE    = 2'd3;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_cur_period;
   logic [CNT_W-1:0] r_held_target;
   logic [POS_W-1:0] r_pos;
   logic             r_step_pulse;
   logic             r_wrap;
   logic             r_paused;

   logic [CNT_W-1:0] w_target;
   logic [CNT_W-1:0] w_next_period;
   logic [POS_W-1:0] w_next_pos;
   logic             w_next_wrap;
   logic             w_run;
   logic             w_terminal;
   logic             w_step_down;

   // While paused the target is the one remembered from the last running speed
   always_comb begin
      w_target = r_held_target;
      unique case (status)
         2'd0:    w_target = c_PERIOD_LOW;
         2'd1:    w_target = c_PERIOD_MID;
         2'd2:    w_target = c_PERIOD_HIGH;
         default: w_target = r_held_target;
      endcase
   end

   assign w_run      = (status != c_ST_PAUSE);
   assign w_terminal = (r_cnt >= (r_cur_period - c_ONE));
   assign ramping    = (r_cur_period != w_target);

   always_comb begin
      w_next_period = w_target;
      if (r_cur_period > w_target) begin
         if ((r_cur_period - w_target) > c_RAMP)
            w_next_period = r_cur_period - c_RAMP;
      end else if ((w_target - r_cur_period) > c_RAMP) begin
         w_next_period = r_cur_period + c_RAMP;
      end
   end

`ifdef STEP_DIR_EN
   assign w_step_down = dir;
`else
   assign w_step_down = 1'b0;
`endif

   always_comb begin
      if (w_step_down) begin
         w_next_pos  = r_pos - POS_W'(1);
         w_next_wrap = (r_pos == '0);
      end else begin
         w_next_pos  = r_pos + POS_W'(1);
         w_next_wrap = &r_pos;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_cur_period  <= c_PERIOD_MID;
         r_held_target <= c_PERIOD_MID;
         r_pos         <= '0;
         r_step_pulse  <= 1'b0;
         r_wrap        <= 1'b0;
         r_paused      <= 1'b0;
      end else begin
         r_paused <= !w_run;
         if (w_run)
            r_held_target <= w_target;

         // clr outranks pause and the terminal step; the period is left alone
         if (clr) begin
            r_cnt        <= '0;
            r_pos        <= '0;
            r_step_pulse <= 1'b0;
            r_wrap       <= 1'b0;
         end else if (!w_run) begin
            r_step_pulse <= 1'b0;
            r_wrap       <= 1'b0;
         end else if (w_terminal) begin
            r_cnt        <= '0;
            r_cur_period <= w_next_period;
            r_pos        <= w_next_pos;
            r_step_pulse <= 1'b1;
            r_wrap       <= w_next_wrap;
         end else begin
            r_cnt        <= r_cnt + c_ONE;
            r_step_pulse <= 1'b0;
            r_wrap       <= 1'b0;
         end
      end
   end

   assign step_pulse = r_step_pulse;
   assign pos        = r_pos;
   assign wrap       = r_wrap;
   assign paused     = r_paused;

endmodule
`default_nettype wire

// File: doc/speed_step_scheduler.md
Name: speed_step_scheduler

Overview:
- Converts the 2-bit speed/pause status from the speed-control FSM into a paced step-enable stream and a wrapping position index for the display/LED shifting datapath.
- Ramps the step period toward each new speed's target in bounded increments rather than jumping, and freezes all timing state while paused.
- Sits between the control FSM and the pattern datapath; the datapath advances only on step_pulse.

Parameters:
- CNT_W, 27, width of the period counter and period registers
- PERIOD_LOW, 50000000, clock cycles per step at status 0
- PERIOD_MID, 25000000, clock cycles per step at status 1; also the reset period
- PERIOD_HIGH, 12500000, clock cycles per step at status 2
- RAMP_STEP, 2000000, maximum change of the current period per emitted step
- POS_W, 4, width of the position index

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- status  input  2  0 low, 1 mid, 2 high, 3 pause; synchronous to clk
- clr  input  1  synchronous clear of count and position; level, acts on every cycle it is high
- step_pulse  output  1  one-cycle step enable to the datapath
- pos  output  POS_W  current position index
- wrap  output  1  one-cycle pulse, coincident with step_pulse, when pos wraps
- paused  output  1  high while status==3
- ramping  output  1  high while cur_period != target period

Behaviour:
- Reset is asynchronous, active-low, with clock clk. Reset values: cnt=0, cur_period=PERIOD_MID, pos=0, step_pulse=0, wrap=0, paused=0.
- Target period is combinational on status: 0->PERIOD_LOW, 1->PERIOD_MID, 2->PERIOD_HIGH. For status 3 the target holds its last non-pause value in a register.
- Constraints: all PERIOD_* values are >=2 and < 2^CNT_W, and RAMP_STEP is >=1. These are not checked in RTL.
- Running (status!=3, clr=0):
  - If cnt >= cur_period-1, the cycle is terminal. On the next clock edge: cnt<=0, step_pulse<=1, pos<=pos+1 (modulo 2^POS_W), and wrap<=1 when the old pos was all ones.
  - In the same edge, cur_period moves toward the target. If |cur_period - target| > RAMP_STEP, it moves by RAMP_STEP in the target's direction; otherwise it becomes the target.
  - On a non-terminal cycle: cnt<=cnt+1, step_pulse<=0, wrap<=0.
  - Consequence: consecutive step_pulse assertions are exactly cur_period counting cycles apart, using the period in force when the interval began.
- Status change while running: the target changes immediately, but cur_period changes only at step boundaries. The interval in progress completes at the old period. Using >= in the terminal test covers any cnt overshoot.
- Paused (status==3):
  - cnt, cur_period, pos and the held target freeze; step_pulse=0 and wrap=0.
  - paused is registered, so it goes high the cycle after status becomes 3.
  - On resume, counting continues from the frozen cnt. Pause cycles are excluded from the interval.
  - Pause to a different speed: the held target is replaced by the new status's target on the resume cycle.
- clr=1 (highest priority apart from reset): cnt<=0, pos<=0, step_pulse<=0, wrap<=0. cur_period is unaffected.
  - clr on a terminal cycle suppresses that pulse.
  - clr while paused still clears cnt and pos.
- ramping is combinational on cur_period vs target (active target, or held target while paused).
- Reset mid-interval: all state returns to reset values immediately. No pulse is emitted.

Optional Feature:
- Macro: STEP_DIR_EN.
- When defined, a port dir (input, 1 bit) is added. With dir=1, pos decrements modulo 2^POS_W on each step, and wrap pulses when the old pos was 0. dir is sampled on the terminal cycle.
- When undefined, there is no dir port and pos always increments.

Test Plan:
- Use PERIOD_LOW=16, PERIOD_MID=8, PERIOD_HIGH=4, RAMP_STEP=2, POS_W=3 for all scenarios.
- Reset release, status=1 held -> step_pulse every 8 cycles; pos reads 1,2,3 after the first three pulses; ramping=0 throughout.
- Steady at status=1, switch to status=2 mid-interval -> pulse intervals 8 (current), 6, 4, 4. ramping=1 from the switch until cur_period=4.
- status=1, pause (status=3) after 3 counting cycles for 10 cycles, then status=1 -> paused=1 during the pause, no pulses, pos unchanged; next pulse 5 counting cycles after resume (interval 18 wall cycles).
- Pause at status=2 (period 4), resume with status=0 -> first interval 4, then 6, 8, ..., 16 (ramping up by 2 per step).
- Run 8 pulses from pos=0 -> pos 7->0 on the 8th pulse with wrap=1 that cycle only. Separately, clr asserted on a terminal cycle at pos=5 -> no pulse, pos=0, next pulse 8 cycles after clr drops.
- (STEP_DIR_EN) dir=1 from pos=0 -> first step gives pos=7 with wrap=1, then 6, 5.
